ex_muldiv: RTL and testbench

- Iterative RV32M multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
- Takes the rs1/rs2 operand values and funct3 of an M-extension instruction held in ID/EX and computes the result over multiple cycles.
- Drives a stall that freezes ID/EX and all upstream stages until the result is ready.
- Presents a one-cycle result pulse for the EX/MEM register to capture.

---
 rtl/ex_muldiv.sv | 142 ++++++++++++++
 tb/tb_ex_muldiv.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M multiply/divide unit in the EX stage.
// Multiplication is radix-2 shift-add. Division is restoring shift-subtract.
// Both work on unsigned operand magnitudes, and the sign is applied once as
// the result is stored.
module ex_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_op_a,
    input  logic [XLEN-1:0] i_op_b,
    input  logic [4:0]      i_rd_addr,
    input  logic            i_flush,
    output logic            o_stall,
    output logic            o_done,
    output logic [XLEN-1:0] o_result,
    output logic [4:0]      o_rd_addr
);
    localparam int              CW        = $clog2(XLEN);
    localparam int              AW        = 2 * XLEN;
    localparam logic [CW-1:0]   LAST_STEP = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t          state_q;
    logic [2:0]      funct_q;
    logic [4:0]      rd_q;        // destination of the operation in flight
    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] op_q;        // multiplicand magnitude, or divisor magnitude
    logic [AW-1:0]   acc_q;       // mul: {partial, multiplier}; div: {remainder, dividend->quotient}
    logic            neg_main_q;  // negate product / quotient
    logic            neg_rem_q;   // negate remainder
    logic [XLEN-1:0] res_q;
    logic [4:0]      rd_out_q;

    logic            accept, is_div, a_signed, b_signed, a_neg, b_neg;
    logic            div_zero, div_ovf, special;
    logic [XLEN-1:0] a_mag, b_mag, special_res;

    // Operand decode at accept time: magnitudes, sign flags, RISC-V special cases.
    assign accept   = (state_q == S_IDLE) && i_valid && !i_flush;
    assign is_div   = i_funct3[2];
    assign a_signed = (i_funct3 == 3'b001) || (i_funct3 == 3'b010) ||
                      (i_funct3 == 3'b100) || (i_funct3 == 3'b110);
    assign b_signed = (i_funct3 == 3'b001) || (i_funct3 == 3'b100) || (i_funct3 == 3'b110);
    assign a_neg    = a_signed && i_op_a[XLEN-1];
    assign b_neg    = b_signed && i_op_b[XLEN-1];
    assign a_mag    = a_neg ? (~i_op_a + XLEN'(1)) : i_op_a;
    assign b_mag    = b_neg ? (~i_op_b + XLEN'(1)) : i_op_b;
    assign div_zero = is_div && (i_op_b == '0);
    assign div_ovf  = is_div && !i_funct3[0] && (i_op_a == MIN_NEG) && (i_op_b == '1);
    assign special  = div_zero || div_ovf;
    assign special_res = div_zero ? (i_funct3[1] ? i_op_a : '1)
                                  : (i_funct3[1] ? '0 : MIN_NEG);

    logic [XLEN:0]   mul_sum, div_shift, div_diff;
    logic [AW-1:0]   acc_step, prod_fix;
    logic [XLEN-1:0] quo_fix, rem_fix, result_fin;

    // One radix-2 step of the datapath, plus the sign-corrected result of that step.
    always_comb begin
        // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
        mul_sum    = {1'b0, acc_q[AW-1:XLEN]} + (acc_q[0] ? {1'b0, op_q} : '0);
        div_shift  = acc_q[AW-1:XLEN-1];
        div_diff   = div_shift - {1'b0, op_q};
        acc_step   = {mul_sum, acc_q[XLEN-1:1]};
        if (funct_q[2]) begin
            if (div_diff[XLEN]) acc_step = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
            else                acc_step = {div_diff[XLEN-1:0],  acc_q[XLEN-2:0], 1'b1};
        end
        prod_fix   = neg_main_q ? (~acc_step + AW'(1)) : acc_step;
        quo_fix    = neg_main_q ? (~acc_step[XLEN-1:0] + XLEN'(1)) : acc_step[XLEN-1:0];
        rem_fix    = neg_rem_q  ? (~acc_step[AW-1:XLEN] + XLEN'(1)) : acc_step[AW-1:XLEN];
        result_fin = rem_fix;
        case (funct_q)
            3'b000:                 result_fin = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: result_fin = prod_fix[AW-1:XLEN];
            3'b100, 3'b101:         result_fin = quo_fix;
            default:                result_fin = rem_fix;
        endcase
    end

    // Control FSM and datapath registers; flush aborts from any state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            funct_q    <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
            op_q       <= '0;
            acc_q      <= '0;
            neg_main_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            res_q      <= '0;
            rd_out_q   <= '0;
        end else if (i_flush) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments, so every register here sees pre-edge values.
            case (state_q)
                S_IDLE: begin
                    if (i_valid) begin
                        funct_q <= i_funct3;
                        rd_q    <= i_rd_addr;
                        cnt_q   <= '0;
                        if (special) begin
                            res_q    <= special_res;
                            rd_out_q <= i_rd_addr;
                            state_q  <= S_DONE;
                        end else begin
                            op_q       <= is_div ? b_mag : a_mag;
                            acc_q      <= {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
                            neg_main_q <= a_neg ^ b_neg;
                            neg_rem_q  <= a_neg;
                            state_q    <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    acc_q <= acc_step;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == LAST_STEP) begin
                        res_q    <= result_fin;
                        rd_out_q <= rd_q;
                        state_q  <= S_DONE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_stall   = accept || (state_q == S_CALC);
    assign o_done    = (state_q == S_DONE) && !i_flush;
    assign o_result  = res_q;
    assign o_rd_addr = rd_out_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: scenario tasks for ex_muldiv, checked against an arithmetic model.
module tb_ex_muldiv;
    localparam int XLEN     = 32;
    localparam int NORM_LAT = XLEN + 1;
    localparam logic [31:0] MIN_NEG = 32'h8000_0000;

    logic        clk = 1'b0, rst_n = 1'b0, valid = 1'b0, flush = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] op_a = '0, op_b = '0;
    logic [4:0]  rd_addr = '0;
    logic        stall, done;
    logic [31:0] result;
    logic [4:0]  rd_out;
    int          total = 0, bad = 0;

    ex_muldiv #(.XLEN(XLEN)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_funct3(funct3),
        .i_op_a(op_a), .i_op_b(op_b), .i_rd_addr(rd_addr), .i_flush(flush),
        .o_stall(stall), .o_done(done), .o_result(result), .o_rd_addr(rd_out)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // RISC-V M-extension semantics computed with 64-bit integer arithmetic.
    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        case (f)
            3'b000: begin p = sa * sb; return p[31:0];  end
            3'b001: begin p = sa * sb; return p[63:32]; end
            3'b010: begin p = sa * ub; return p[63:32]; end
            3'b011: begin p = ua * ub; return p[63:32]; end
            3'b100: begin
                if (b == 0) return '1;
                if (a == MIN_NEG && b == '1) return MIN_NEG;
                p = sa / sb; return p[31:0];
            end
            3'b101: return (b == 0) ? '1 : a / b;
            3'b110: begin
                if (b == 0) return a;
                if (a == MIN_NEG && b == '1) return '0;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return f[2] && ((b == 0) || (!f[0] && a == MIN_NEG && b == '1));
    endfunction

    // Drive one instruction at the current negedge, then collect its o_done beat.
    // lat = negedges after driving until o_done; stn = cycles with o_stall high.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, output logic [31:0] res, output logic [4:0] rdo,
                          output int lat, output int stn);
        bit seen_done;
        res = 'x; rdo = 'x; lat = -1;
        funct3 = f; op_a = a; op_b = b; rd_addr = rd; valid = 1'b1;
        #1;
        stn = stall ? 1 : 0;
        for (int i = 1; i <= 80; i++) begin
            @(negedge clk);
            if (stall) stn++;
            seen_done = done;
            if (seen_done) begin res = result; rdo = rd_out; lat = i; end
            if (i == 1) begin
                valid = 1'b0; op_a = $urandom(); op_b = $urandom(); rd_addr = 5'($urandom());
            end
            if (seen_done) break;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; valid = 1'b0; flush = 1'b0;
        #1;
        total++; if (done !== 1'b0)   begin bad++; $display("FAIL reset_done: got %0b want 0", done); end
        total++; if (stall !== 1'b0)  begin bad++; $display("FAIL reset_stall: got %0b want 0", stall); end
        total++; if (result !== '0)   begin bad++; $display("FAIL reset_result: got %h want 0", result); end
        total++; if (rd_out !== '0)   begin bad++; $display("FAIL reset_rd: got %0d want 0", rd_out); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mul();
        logic [2:0]  tf[4] = '{3'b000, 3'b001, 3'b011, 3'b010};
        logic [31:0] ta[4] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] tb[4] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] te[4] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
        logic [31:0] res; logic [4:0] rdo; int lat, stn;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            run_op(tf[i], ta[i], tb[i], 5'(i + 3), res, rdo, lat, stn);
            total++; if (res !== te[i]) begin bad++; $display("FAIL mul_result[%0d]: got %h want %h", i, res, te[i]); end
            total++; if (rdo !== 5'(i + 3)) begin bad++; $display("FAIL mul_rd[%0d]: got %0d want %0d", i, rdo, i + 3); end
            total++; if (lat != NORM_LAT) begin bad++; $display("FAIL mul_latency[%0d]: got %0d want %0d", i, lat, NORM_LAT); end
            if (i == 0) begin
                total++; if (stn != NORM_LAT) begin bad++; $display("FAIL mul_stall_cycles: got %0d want %0d", stn, NORM_LAT); end
                @(negedge clk);
                total++; if (done !== 1'b0) begin bad++; $display("FAIL mul_done_width: got %0b want 0", done); end
                total++; if (result !== te[0]) begin bad++; $display("FAIL mul_result_hold: got %h want %h", result, te[0]); end
            end
        end
    endtask

    task automatic test_div();
        logic [2:0]  tf[4] = '{3'b100, 3'b110, 3'b101, 3'b111};
        logic [31:0] ta[4] = '{32'hFFFF_FFEC, 32'hFFFF_FFEC, 32'd100, 32'd100};
        logic [31:0] tb[4] = '{32'd6, 32'd6, 32'd7, 32'd7};
        logic [31:0] te[4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'd14, 32'd2};
        logic [31:0] res; logic [4:0] rdo; int lat, stn;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            run_op(tf[i], ta[i], tb[i], 5'(i + 20), res, rdo, lat, stn);
            total++; if (res !== te[i]) begin bad++; $display("FAIL div_result[%0d]: got %h want %h", i, res, te[i]); end
            total++; if (rdo !== 5'(i + 20)) begin bad++; $display("FAIL div_rd[%0d]: got %0d want %0d", i, rdo, i + 20); end
            total++; if (lat != NORM_LAT) begin bad++; $display("FAIL div_latency[%0d]: got %0d want %0d", i, lat, NORM_LAT); end
        end
    endtask

    task automatic test_special();
        logic [2:0]  tf[4] = '{3'b101, 3'b110, 3'b100, 3'b110};
        logic [31:0] ta[4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] tb[4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] te[4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
        logic [31:0] res; logic [4:0] rdo; int lat, stn;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            run_op(tf[i], ta[i], tb[i], 5'(i + 10), res, rdo, lat, stn);
            total++; if (res !== te[i]) begin bad++; $display("FAIL special_result[%0d]: got %h want %h", i, res, te[i]); end
            total++; if (rdo !== 5'(i + 10)) begin bad++; $display("FAIL special_rd[%0d]: got %0d want %0d", i, rdo, i + 10); end
            total++; if (lat != 1) begin bad++; $display("FAIL special_latency[%0d]: got %0d want 1", i, lat); end
        end
    endtask

    task automatic test_flush();
        logic [31:0] res; logic [4:0] rdo; int lat, stn;
        // Abort a long divide at step 10, then accept a fresh one immediately.
        @(negedge clk);
        funct3 = 3'b101; op_a = 32'd1000; op_b = 32'd7; rd_addr = 5'd9; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL flush_stall: got %0b want 0", stall); end
        total++; if (done !== 1'b0)  begin bad++; $display("FAIL flush_done: got %0b want 0", done); end
        flush = 1'b0;
        run_op(3'b101, 32'd9, 32'd3, 5'd12, res, rdo, lat, stn);
        total++; if (res !== 32'd3)  begin bad++; $display("FAIL flush_next_result: got %h want 3", res); end
        total++; if (rdo !== 5'd12)  begin bad++; $display("FAIL flush_next_rd: got %0d want 12", rdo); end
        total++; if (lat != NORM_LAT) begin bad++; $display("FAIL flush_next_latency: got %0d want %0d", lat, NORM_LAT); end
        // Flush during the DONE cycle suppresses o_done.
        @(negedge clk);
        funct3 = 3'b101; op_a = 32'd5; op_b = 32'd0; rd_addr = 5'd13; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        #1;
        total++; if (done !== 1'b1) begin bad++; $display("FAIL flush_done_pre: got %0b want 1", done); end
        flush = 1'b1;
        #1;
        total++; if (done !== 1'b0) begin bad++; $display("FAIL flush_done_forced: got %0b want 0", done); end
        @(negedge clk);
        flush = 1'b0;
        // Flush wins over valid in IDLE: nothing is accepted.
        funct3 = 3'b000; op_a = 32'd2; op_b = 32'd3; valid = 1'b1; flush = 1'b1;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL flush_prio_stall: got %0b want 0", stall); end
        @(negedge clk);
        valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        total++; if (stall !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL flush_prio_accept: got stall=%0b done=%0b want 0/0", stall, done);
        end
    endtask

    task automatic test_async_reset();
        int done_cnt = 0;
        @(negedge clk);
        funct3 = 3'b000; op_a = 32'd123; op_b = 32'd456; rd_addr = 5'd17; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        repeat (8) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++; if (done !== 1'b0)  begin bad++; $display("FAIL areset_done: got %0b want 0", done); end
        total++; if (result !== '0)  begin bad++; $display("FAIL areset_result: got %h want 0", result); end
        total++; if (rd_out !== '0)  begin bad++; $display("FAIL areset_rd: got %0d want 0", rd_out); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL areset_stall: got %0b want 0", stall); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        total++; if (done_cnt != 0) begin bad++; $display("FAIL areset_no_done: got %0d pulses want 0", done_cnt); end
    endtask

    task automatic test_back_to_back();
        int lat1 = -1, gap = -1;
        bit idle_stall = 1'b0;
        @(negedge clk);
        funct3 = 3'b000; op_a = 32'd2; op_b = 32'd3; rd_addr = 5'd4; valid = 1'b1;
        for (int i = 1; i <= 80; i++) begin
            @(negedge clk);
            if (done) begin lat1 = i; break; end
        end
        total++; if (lat1 != NORM_LAT) begin bad++; $display("FAIL b2b_first_latency: got %0d want %0d", lat1, NORM_LAT); end
        total++; if (result !== 32'd6) begin bad++; $display("FAIL b2b_first_result: got %h want 6", result); end
        total++; if (rd_out !== 5'd4)  begin bad++; $display("FAIL b2b_first_rd: got %0d want 4", rd_out); end
        // The pipeline advances on the DONE edge; the next instruction is held valid.
        op_a = 32'd4; op_b = 32'd5; rd_addr = 5'd5;
        for (int j = 1; j <= 80; j++) begin
            @(negedge clk);
            if (j == 1) idle_stall = stall;
            if (done) begin gap = j; break; end
        end
        total++; if (idle_stall !== 1'b1) begin bad++; $display("FAIL b2b_idle_stall: got %0b want 1", idle_stall); end
        total++; if (gap != NORM_LAT + 1) begin bad++; $display("FAIL b2b_gap: got %0d want %0d", gap, NORM_LAT + 1); end
        total++; if (result !== 32'd20) begin bad++; $display("FAIL b2b_second_result: got %h want 20", result); end
        total++; if (rd_out !== 5'd5)   begin bad++; $display("FAIL b2b_second_rd: got %0d want 5", rd_out); end
        valid = 1'b0;
        @(negedge clk);
        total++; if (done !== 1'b0 || stall !== 1'b0) begin
            bad++; $display("FAIL b2b_after: got done=%0b stall=%0b want 0/0", done, stall);
        end
    endtask

    task automatic test_random();
        logic [2:0] f; logic [31:0] a, b, exp_res; logic [4:0] rd;
        logic [31:0] res; logic [4:0] rdo; int lat, stn, exp_lat;
        for (int n = 0; n < 40; n++) begin
            f  = 3'($urandom_range(0, 7));
            a  = $urandom();
            b  = $urandom();
            rd = 5'($urandom());
            case ($urandom_range(0, 7))
                0: b = '0;
                1: begin a = MIN_NEG; b = '1; end
                2: b = 32'($urandom_range(1, 15));
                3: a = 32'($urandom_range(0, 255));
                default: ;
            endcase
            exp_res = ref_model(f, a, b);
            exp_lat = is_special(f, a, b) ? 1 : NORM_LAT;
            @(negedge clk);
            run_op(f, a, b, rd, res, rdo, lat, stn);
            total++; if (res !== exp_res || rdo !== rd || lat != exp_lat) begin
                bad++;
                $display("FAIL random[%0d] f=%0d a=%h b=%h: got res=%h rd=%0d lat=%0d want res=%h rd=%0d lat=%0d",
                         n, f, a, b, res, rdo, lat, exp_res, rd, exp_lat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_flush();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
